// File: rtl/btn_debounce_repeat.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_repeat
// Purpose  : Conditions the four raw direction buttons {dn, up, rgt, lft}.
//            Each button is synchronised, debounced and edge-detected. Move
//            pulses are produced on a press and, optionally, repeat while
//            the button is held. A move pulse is suppressed while both
//            buttons of an opposing pair (lft/rgt, up/dn) are held.
// Ports    : clk             pixel clock
//            rst             synchronous, active-high reset
//            i_btn_raw       asynchronous raw buttons, 1 = pressed
//            o_btn_level     debounced level
//            o_btn_press     1-cycle pulse on an accepted press
//            o_btn_release   1-cycle pulse on an accepted release
//            o_move_pulse    1-cycle step request (press or repeat), masked
// Options  : BTN_AUTO_REPEAT_EN - when defined, hold-to-repeat pulses are
//            generated; otherwise one move pulse per press.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_repeat #(
   parameter int unsigned DEBOUNCE_CYCLES = 1485000,
   parameter int unsigned REPEAT_DELAY    = 74250000,
   parameter int unsigned REPEAT_PERIOD   = 14850000,
   parameter int unsigned NUM_BTN         = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] i_btn_raw,
   output logic [NUM_BTN-1:0] o_btn_level,
   output logic [NUM_BTN-1:0] o_btn_press,
   output logic [NUM_BTN-1:0] o_btn_release,
   output logic [NUM_BTN-1:0] o_move_pulse
);

   localparam int unsigned c_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int unsigned c_MAX   = (c_MAX_A > REPEAT_PERIOD) ? c_MAX_A : REPEAT_PERIOD;
   localparam int unsigned c_CW    = $clog2(c_MAX) + 1;

   localparam logic [c_CW-1:0] c_DB_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_ARM  = 2'd1;
   localparam logic [1:0] c_S_HELD = 2'd2;
   localparam logic [1:0] c_S_REL  = 2'd3;

   logic [NUM_BTN-1:0] r_sync1;
   logic [NUM_BTN-1:0] r_sync2;
   logic [NUM_BTN-1:0] w_level_nxt;
   logic [NUM_BTN-1:0] w_press_nxt;
   logic [NUM_BTN-1:0] w_rel_nxt;
   logic [NUM_BTN-1:0] w_cand_nxt;
   logic [NUM_BTN-1:0] w_opp_level;

   // Two-flop synchroniser; r_sync2 is the sampled button value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      logic            w_s;
      logic [1:0]      r_state;
      logic [1:0]      w_state_nxt;
      logic [c_CW-1:0] r_dcnt;
      logic [c_CW-1:0] w_dcnt_nxt;
      logic            w_accept_press;
      logic            w_lv;
      logic            w_pr;
      logic            w_rl;
      logic            w_rpt;

      assign w_s            = r_sync2[g];
      assign w_accept_press = (r_state == c_S_ARM) && w_s && (r_dcnt == c_DB_LAST);

      // State register
      always_ff @(posedge clk) begin
         if (rst) begin
            r_state <= c_S_IDLE;
            r_dcnt  <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
         end
      end

      // Next-state logic
      always_comb begin
         w_state_nxt = r_state;
         w_dcnt_nxt  = r_dcnt;
         case (r_state)
            c_S_IDLE: begin
               if (w_s) begin
                  w_state_nxt = c_S_ARM;
                  w_dcnt_nxt  = c_CW'(1);
               end
            end
            c_S_ARM: begin
               if (!w_s) begin
                  w_state_nxt = c_S_IDLE;
                  w_dcnt_nxt  = '0;
               end else if (r_dcnt == c_DB_LAST) begin
                  w_state_nxt = c_S_HELD;
               end else begin
                  w_dcnt_nxt  = r_dcnt + c_CW'(1);
               end
            end
            c_S_HELD: begin
               if (!w_s) begin
                  w_state_nxt = c_S_REL;
                  w_dcnt_nxt  = c_CW'(1);
               end
            end
            c_S_REL: begin
               // A return to 1 before the release is accepted is a glitch:
               // go back to HELD silently, without a new press.
               if (w_s) begin
                  w_state_nxt = c_S_HELD;
               end else if (r_dcnt == c_DB_LAST) begin
                  w_state_nxt = c_S_IDLE;
                  w_dcnt_nxt  = '0;
               end else begin
                  w_dcnt_nxt  = r_dcnt + c_CW'(1);
               end
            end
            default: begin
               w_state_nxt = c_S_IDLE;
               w_dcnt_nxt  = '0;
            end
         endcase
      end

`ifdef BTN_AUTO_REPEAT_EN
      localparam logic [c_CW-1:0] c_RPT_FIRST = c_CW'(REPEAT_DELAY - 1);
      localparam logic [c_CW-1:0] c_RPT_WRAP  = c_CW'(REPEAT_DELAY - REPEAT_PERIOD);

      logic [c_CW-1:0] r_rcnt;
      logic [c_CW-1:0] w_rcnt_nxt;

      // rcnt only advances in HELD, so a glitch through RELEASE freezes it.
      // After each repeat it jumps back by one period, so every later repeat
      // is also detected at c_RPT_FIRST and the counter never overflows.
      always_comb begin
         w_rcnt_nxt = r_rcnt;
         if (w_accept_press) begin
            w_rcnt_nxt = '0;
         end else if (r_state == c_S_HELD) begin
            w_rcnt_nxt = (r_rcnt == c_RPT_FIRST) ? c_RPT_WRAP : (r_rcnt + c_CW'(1));
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_rcnt <= '0;
         end else begin
            r_rcnt <= w_rcnt_nxt;
         end
      end

      assign w_rpt = (r_state == c_S_HELD) && (r_rcnt == c_RPT_FIRST);
`else
      assign w_rpt = 1'b0;
`endif

      // Output logic (registered at the top level)
      always_comb begin
         w_pr = w_accept_press;
         w_rl = (r_state == c_S_REL) && !w_s && (r_dcnt == c_DB_LAST);
         w_lv = (w_state_nxt == c_S_HELD) || (w_state_nxt == c_S_REL);
      end

      assign w_level_nxt[g] = w_lv;
      assign w_press_nxt[g] = w_pr;
      assign w_rel_nxt[g]   = w_rl;
      assign w_cand_nxt[g]  = w_pr | w_rpt;
   end

   // Opposite of each bit: lft<->rgt, up<->dn. The next-cycle level is used
   // so that a pulse coinciding with both levels becoming 1 is suppressed.
   assign w_opp_level = {w_level_nxt[2], w_level_nxt[3], w_level_nxt[0], w_level_nxt[1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         o_btn_level   <= '0;
         o_btn_press   <= '0;
         o_btn_release <= '0;
         o_move_pulse  <= '0;
      end else begin
         o_btn_level   <= w_level_nxt;
         o_btn_press   <= w_press_nxt;
         o_btn_release <= w_rel_nxt;
         o_move_pulse  <= w_cand_nxt & ~w_opp_level;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_repeat.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_repeat
// Purpose  : Directed self-checking bench for btn_debounce_repeat with
//            DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10.
//            Cycle index n is the edge that samples the driven input; the
//            outputs are observed just after edge n. A pulse observed after
//            edge 9 is the one a downstream flop samples at edge 10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_repeat;

`ifdef BTN_AUTO_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] i_btn_raw;
   logic [3:0] o_btn_level;
   logic [3:0] o_btn_press;
   logic [3:0] o_btn_release;
   logic [3:0] o_move_pulse;

   int checks;
   int failures;

   btn_debounce_repeat #(
      .DEBOUNCE_CYCLES (8),
      .REPEAT_DELAY    (40),
      .REPEAT_PERIOD   (10),
      .NUM_BTN         (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_btn_raw     (i_btn_raw),
      .o_btn_level   (o_btn_level),
      .o_btn_press   (o_btn_press),
      .o_btn_release (o_btn_release),
      .o_move_pulse  (o_move_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs for edge n, then advance to just after that edge.
   task automatic step(input logic [3:0] raw, input logic r);
      @(negedge clk);
      i_btn_raw = raw;
      rst       = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] raw);
      @(negedge clk);
      rst       = 1'b1;
      i_btn_raw = raw;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      i_btn_raw = 4'b0000;
   endtask

   task automatic test_reset();
      logic [15:0] obs, exp;
      do_reset(4'b1111);
      checks++;
      obs = {o_btn_level, o_btn_press, o_btn_release, o_move_pulse};
      if (obs !== 16'h0000) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", obs, 16'h0000);
      end
      // All four pressed together: no press before edge 9, all opposing.
      for (int n = 0; n < 12; n++) begin
         step(4'b1111, 1'b0);
         exp = {(n >= 9) ? 4'b1111 : 4'b0000, (n == 9) ? 4'b1111 : 4'b0000, 4'b0000, 4'b0000};
         obs = {o_btn_level, o_btn_press, o_btn_release, o_move_pulse};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL reset_all_press n=%0d got=%h exp=%h", n, obs, exp);
         end
      end
   endtask

   task automatic test_clean_step();
      logic [15:0] obs, exp;
      logic        mv;
      do_reset(4'b0000);
      for (int n = 0; n < 120; n++) begin
         step((n < 100) ? 4'b0001 : 4'b0000, 1'b0);
         mv  = (n == 9) || (REP && n >= 49 && n <= 99 && ((n - 49) % 10) == 0);
         exp = {(n >= 9 && n <= 108) ? 4'b0001 : 4'b0000,
                (n == 9) ? 4'b0001 : 4'b0000,
                (n == 109) ? 4'b0001 : 4'b0000,
                {3'b000, mv}};
         obs = {o_btn_level, o_btn_press, o_btn_release, o_move_pulse};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL clean_step n=%0d got=%h exp=%h", n, obs, exp);
         end
      end
   endtask

   task automatic test_bounce();
      logic [15:0] obs, exp;
      logic        b;
      do_reset(4'b0000);
      for (int n = 0; n < 70; n++) begin
         b = (n < 30) ? (((n / 3) % 2) == 0) : (n >= 40);
         step({2'b00, b, 1'b0}, 1'b0);
         exp = {(n >= 49) ? 4'b0010 : 4'b0000,
                (n == 49) ? 4'b0010 : 4'b0000,
                4'b0000,
                (n == 49) ? 4'b0010 : 4'b0000};
         obs = {o_btn_level, o_btn_press, o_btn_release, o_move_pulse};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL bounce n=%0d got=%h exp=%h", n, obs, exp);
         end
      end
   endtask

   task automatic test_auto_repeat();
      logic [15:0] obs, exp;
      logic        mv;
      do_reset(4'b0000);
      for (int n = 0; n < 115; n++) begin
         step((n < 100) ? 4'b0100 : 4'b0000, 1'b0);
         mv  = (n == 9) || (REP && n >= 49 && n <= 99 && ((n - 49) % 10) == 0);
         exp = {(n >= 9 && n <= 108) ? 4'b0100 : 4'b0000,
                (n == 9) ? 4'b0100 : 4'b0000,
                (n == 109) ? 4'b0100 : 4'b0000,
                {1'b0, mv, 2'b00}};
         obs = {o_btn_level, o_btn_press, o_btn_release, o_move_pulse};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL auto_repeat n=%0d got=%h exp=%h", n, obs, exp);
         end
      end
   endtask

   task automatic test_opposing();
      logic [15:0] obs, exp;
      logic        lft, rgt, mv;
      do_reset(4'b0000);
      for (int n = 0; n < 130; n++) begin
         lft = (n < 110);
         rgt = (n >= 20 && n < 60);
         step({2'b00, rgt, lft}, 1'b0);
         // lft repeats at 49 and 59 are masked by rgt; they resume at 69.
         mv  = (n == 9) || (REP && n >= 69 && n <= 109 && ((n - 69) % 10) == 0);
         exp = {2'b00, (n >= 29 && n <= 68), (n >= 9 && n <= 118),
                2'b00, (n == 29), (n == 9),
                2'b00, (n == 69), (n == 119),
                3'b000, mv};
         obs = {o_btn_level, o_btn_press, o_btn_release, o_move_pulse};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL opposing n=%0d got=%h exp=%h", n, obs, exp);
         end
      end
   endtask

   task automatic test_glitch_held();
      logic [15:0] obs, exp;
      logic        d, mv;
      do_reset(4'b0000);
      for (int n = 0; n < 100; n++) begin
         d = (n < 80) && !(n >= 30 && n < 34);
         step({d, 3'b000}, 1'b0);
         // Repeats shift by the 4 frozen cycles: 53, 63, 73 instead of 49...
         mv  = (n == 9) || (REP && (n == 53 || n == 63 || n == 73));
         exp = {(n >= 9 && n <= 88) ? 4'b1000 : 4'b0000,
                (n == 9) ? 4'b1000 : 4'b0000,
                (n == 89) ? 4'b1000 : 4'b0000,
                {mv, 3'b000}};
         obs = {o_btn_level, o_btn_press, o_btn_release, o_move_pulse};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL glitch_held n=%0d got=%h exp=%h", n, obs, exp);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      logic [15:0] obs, exp;
      logic        on;
      do_reset(4'b0000);
      for (int n = 0; n < 70; n++) begin
         step(4'b0001, (n == 45));
         on  = (n == 9) || (n == 55);
         exp = {((n >= 9 && n <= 44) || n >= 55) ? 4'b0001 : 4'b0000,
                on ? 4'b0001 : 4'b0000,
                4'b0000,
                on ? 4'b0001 : 4'b0000};
         obs = {o_btn_level, o_btn_press, o_btn_release, o_move_pulse};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL reset_mid_hold n=%0d got=%h exp=%h", n, obs, exp);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] obs, exp;
      logic [3:0]  pat;
      logic [3:0]  mv_exp;
      for (int p = 0; p < 2; p++) begin
         pat    = (p == 0) ? 4'b0101 : 4'b0011;
         mv_exp = (p == 0) ? 4'b0101 : 4'b0000;
         do_reset(4'b0000);
         for (int n = 0; n < 35; n++) begin
            step((n < 20) ? pat : 4'b0000, 1'b0);
            exp = {(n >= 9 && n <= 28) ? pat : 4'b0000,
                   (n == 9) ? pat : 4'b0000,
                   (n == 29) ? pat : 4'b0000,
                   (n == 9) ? mv_exp : 4'b0000};
            obs = {o_btn_level, o_btn_press, o_btn_release, o_move_pulse};
            checks++;
            if (obs !== exp) begin
               failures++;
               $display("FAIL simultaneous pat=%b n=%0d got=%h exp=%h", pat, n, obs, exp);
            end
         end
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      i_btn_raw = 4'b0000;
      test_reset();
      test_clean_step();
      test_bounce();
      test_auto_repeat();
      test_opposing();
      test_glitch_held();
      test_reset_mid_hold();
      test_simultaneous();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
